// File: rtl/adder_seq_arbiter_pkg.sv
// Shared definitions for the bit-serial arbitrated adder.
//   DEFAULT_WIDTH : default operand width
//   state_t       : controller state encoding (IDLE / RUN / DONE)
package adder_seq_arbiter_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/adder_seq_arbiter_adder_1bit.sv
// Single-bit full adder. The serial adder reuses one instance for every bit position.
// Ports:
//   i1, i2  : operand bits
//   cn      : carry in
//   result  : sum bit
//   cn_out  : carry out (majority of the three inputs)
module adder_1bit (
    input  logic i1,
    input  logic i2,
    input  logic cn,
    output logic result,
    output logic cn_out
);

    assign result = i1 ^ i2 ^ cn;
    assign cn_out = (i1 & i2) | (i1 & cn) | (i2 & cn);

endmodule

// File: rtl/adder_seq_arbiter.sv
// Two-requester, round-robin arbitrated, bit-serial unsigned adder.
// One winning requester's operands are latched and summed one bit per clock,
// LSB first, through a single full-adder cell.
//
// Handshake: a requester raises reqN (level) with stable operands and holds it
// until doneN's cycle; the operands are captured on the granting edge, so later
// changes on the ports (including dropping req) do not affect the operation.
// done is a one-cycle pulse in which sum is valid; sum stays valid until the
// next grant clears it.
//
// Ports:
//   sys_clk, sys_rst_n  : clock, asynchronous active-low reset
//   req0/req1           : level requests
//   a0,b0,cin0          : requester 0 operands and carry-in
//   a1,b1,cin1          : requester 1 operands and carry-in
//   gnt[1:0]            : one-hot grant, zero in IDLE
//   busy                : high in RUN and DONE
//   done                : one-cycle result pulse
//   sum[WIDTH:0]        : result, sum[WIDTH] is carry-out
//   dbg_state[1:0]      : current controller state
module adder_seq_arbiter
    import adder_seq_arbiter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             cin0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic             cin1,
    output logic [1:0]       gnt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   sum,
    output logic [1:0]       dbg_state
);

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_owner;      // granted requester, latched with the operands
    logic             r_last;       // requester served last
    logic [WIDTH-1:0] r_mask;       // one-hot current bit position
    logic             r_carry;
    logic [WIDTH:0]   r_sum;

    logic             w_any_req;
    logic             w_pick1;
    logic             w_a_bit;
    logic             w_b_bit;
    logic             w_bit_sum;
    logic             w_bit_cout;

    // Round-robin: a lone requester wins; on a tie the one not served last wins.
    assign w_any_req = req0 | req1;
    assign w_pick1   = req1 & (~req0 | ~r_last);

    // Operand bits at the current mask position.
    assign w_a_bit = |(r_a & r_mask);
    assign w_b_bit = |(r_b & r_mask);

    adder_1bit u_adder_1bit (
        .i1     (w_a_bit),
        .i2     (w_b_bit),
        .cn     (r_carry),
        .result (w_bit_sum),
        .cn_out (w_bit_cout)
    );

    // State register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_any_req)         w_next_state = ST_RUN;
            ST_RUN:  if (r_mask[WIDTH-1])   w_next_state = ST_DONE;
            ST_DONE:                        w_next_state = ST_IDLE;
            default:                        w_next_state = ST_IDLE;
        endcase
    end

    // Datapath registers
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_owner <= 1'b0;
            r_last  <= 1'b1;
            r_mask  <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_owner <= w_pick1;
                        r_a     <= w_pick1 ? a1 : a0;
                        r_b     <= w_pick1 ? b1 : b0;
                        r_carry <= w_pick1 ? cin1 : cin0;
                        r_mask  <= {{(WIDTH-1){1'b0}}, 1'b1};
                        r_sum   <= '0;
                    end
                end
                ST_RUN: begin
                    // Replace only the bit selected by the mask.
                    r_sum[WIDTH-1:0] <= (r_sum[WIDTH-1:0] & ~r_mask)
                                      | ({WIDTH{w_bit_sum}} & r_mask);
                    if (r_mask[WIDTH-1]) begin
                        r_sum[WIDTH] <= w_bit_cout;
                    end
                    r_carry <= w_bit_cout;
                    r_mask  <= r_mask << 1;
                end
                ST_DONE: begin
                    r_last <= r_owner;
                end
                default: ;
            endcase
        end
    end

    // Output logic
    always_comb begin
        gnt  = 2'b00;
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            ST_RUN: begin
                gnt  = r_owner ? 2'b10 : 2'b01;
                busy = 1'b1;
            end
            ST_DONE: begin
                gnt  = r_owner ? 2'b10 : 2'b01;
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    assign sum       = r_sum;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_adder_seq_arbiter.sv
module tb_adder_seq_arbiter;

  localparam int W = 8;

  logic         sys_clk;
  logic         sys_rst_n;
  logic         req0, req1;
  logic [W-1:0] a0, b0, a1, b1;
  logic         cin0, cin1;
  logic [1:0]   gnt;
  logic         busy, done;
  logic [W:0]   sum;
  logic [1:0]   dbg_state;

  int errors = 0;
  int checks = 0;

  // Expected {gnt, sum} per completed operation.
  logic [W+2:0] exp_q[$];

  adder_seq_arbiter #(.WIDTH(W)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .req0      (req0),
    .req1      (req1),
    .a0        (a0),
    .b0        (b0),
    .cin0      (cin0),
    .a1        (a1),
    .b1        (b1),
    .cin1      (cin1),
    .gnt       (gnt),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, act=running exp=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: act=%0h exp=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic prev_done = 1'b0;
  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      check("gnt_not_two_hot", {31'd0, gnt != 2'b11}, 32'd1);
      check("busy_eq_gnt", {31'd0, busy}, {31'd0, gnt != 2'b00});
      check("done_one_cycle", {31'd0, !(done && prev_done)}, 32'd1);
      if (done) begin
        check("done_expected", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          logic [W+2:0] e;
          e = exp_q.pop_front();
          check("result_gnt_sum", {21'd0, gnt, sum}, {21'd0, e});
        end
      end
      prev_done <= done;
    end else begin
      prev_done <= 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  // Waits for done; n = number of cycles with gnt high up to and including done.
  task automatic wait_done(output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge sys_clk);
      if (gnt != 2'b00) n++;
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_gnt(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge sys_clk);
      if (gnt != 2'b00) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_single(input int who, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic cin, input logic [W+2:0] exp);
    int n;
    bit ok;
    exp_q.push_back(exp);
    if (who == 0) begin
      a0 = a; b0 = b; cin0 = cin; req0 = 1'b1;
    end else begin
      a1 = a; b1 = b; cin1 = cin; req1 = 1'b1;
    end
    wait_done(n, ok);
    req0 = 1'b0;
    req1 = 1'b0;
    check("done_timeout", {31'd0, ok}, 32'd1);
    check("gnt_cycles_to_done", n, W + 1);
    @(negedge sys_clk);
    check("idle_after_done", {30'd0, gnt}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    bit ok;

    sys_rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; cin0 = 1'b0;
    a1 = '0; b1 = '0; cin1 = 1'b0;
    #1;
    check("rst_gnt", {30'd0, gnt}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_sum", {23'd0, sum}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);

    // Both requesters held from reset: grants alternate starting with 0.
    a0 = 8'h12; b0 = 8'h34; cin0 = 1'b0;
    a1 = 8'h80; b1 = 8'h80; cin1 = 1'b1;
    req0 = 1'b1; req1 = 1'b1;
    exp_q.push_back({2'b01, 9'h046});
    exp_q.push_back({2'b10, 9'h101});
    exp_q.push_back({2'b01, 9'h046});
    exp_q.push_back({2'b10, 9'h101});
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_done(n, ok);
      if (k == 3) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
      check("alt_done_timeout", {31'd0, ok}, 32'd1);
      check("alt_gnt_cycles", n, W + 1);
      @(negedge sys_clk);
      check("alt_idle_gap", {30'd0, gnt}, 32'd0);
    end
    @(negedge sys_clk);
    check("alt_no_more_grant", {30'd0, gnt}, 32'd0);

    // Single requesters.
    run_single(0, 8'h5A, 8'h33, 1'b0, {2'b01, 9'h08D});
    run_single(1, 8'hFF, 8'hFF, 1'b1, {2'b10, 9'h1FF});
    run_single(1, 8'h00, 8'h00, 1'b0, {2'b10, 9'h000});
    run_single(0, 8'hFF, 8'h00, 1'b1, {2'b01, 9'h100});

    // Operands change and req drops mid-RUN: result unaffected.
    a0 = 8'h01; b0 = 8'h01; cin0 = 1'b0;
    exp_q.push_back({2'b01, 9'h002});
    req0 = 1'b1;
    wait_gnt(ok);
    check("midrun_gnt_timeout", {31'd0, ok}, 32'd1);
    repeat (2) @(negedge sys_clk);
    a0 = 8'hFF; b0 = 8'hFF; cin0 = 1'b1; req0 = 1'b0;
    wait_done(n, ok);
    check("midrun_done_timeout", {31'd0, ok}, 32'd1);
    @(negedge sys_clk);
    check("midrun_idle", {30'd0, gnt}, 32'd0);

    // Reset in RUN cycle 4 aborts without a done pulse.
    a0 = 8'h40; b0 = 8'h40; cin0 = 1'b0;
    req0 = 1'b1;
    wait_gnt(ok);
    check("abort_gnt_timeout", {31'd0, ok}, 32'd1);
    repeat (3) @(negedge sys_clk);
    check("abort_in_run", {30'd0, dbg_state}, 32'd1);
    #2;
    sys_rst_n = 1'b0;
    req0 = 1'b0;
    #1;
    check("abort_gnt", {30'd0, gnt}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_sum", {23'd0, sum}, 32'd0);
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge sys_clk);
      check("abort_stays_idle", {30'd0, gnt}, 32'd0);
    end
    run_single(0, 8'h10, 8'h20, 1'b0, {2'b01, 9'h030});

    repeat (2) @(negedge sys_clk);
    check("queue_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
